muldiv_issue_ctrl: RTL and testbench
====================================

Name: muldiv_issue_ctrl

Overview:
Sequencing controller for the 5-stage M-extension multiply/divide unit in the execute stage.
- Accepts one MUL/DIV op at a time from issue, latches operands, fires a one-cycle start to the unit and tracks the in-flight destination register for hazard detection.
- Captures the unit's result and wins the shared register-file write port over the ALU for one cycle.
- Handles pipeline flush of an in-flight op.

Parameters:
MUL_LATENCY, 5, nominal cycles from mul_start_o to mul_done_i; sizes the cycle counter.
TIMEOUT, 16, watchdog limit in WAIT cycles; used only with MULDIV_WATCHDOG_EN; must be > MUL_LATENCY.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid_i  in  1  issue presents an M-op
req_ready_o  out  1  controller can accept an M-op
req_funct3_i  in  FUNCT3_SIZE  op select
req_op1_i, req_op2_i  in  WD_SIZE  operands
req_rd_i  in  INSTR_REG_SIZE  destination register
req_reg_write_i  in  1  op writes rd
mul_start_o  out  1  one-cycle start pulse to the unit
mul_funct3_o  out  FUNCT3_SIZE  latched funct3, held stable while busy
mul_op1_o, mul_op2_o  out  WD_SIZE  latched operands, held stable while busy
mul_done_i  in  1  unit result valid
mul_result_i  in  WD_SIZE  unit result
flush_i  in  1  kill the in-flight op
dec_rs1_i, dec_rs2_i  in  INSTR_REG_SIZE  source registers of the instruction in decode
hazard_o  out  1  decode must stall on an RAW dependency
alu_wb_valid_i  in  1  ALU requests the write port
alu_wb_ready_o  out  1  ALU write granted
wb_valid_o  out  1  controller writes the register file
wb_rd_o  out  INSTR_REG_SIZE  write address
wb_data_o  out  WD_SIZE  write data
busy_o  out  1  state != IDLE
error_o  out  1  watchdog timeout pulse

Behaviour:
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- Reset (asynchronous, active-high) forces state IDLE, counter 0 and all latches 0. All outputs read 0 except req_ready_o=1 and alu_wb_ready_o=1.
- IDLE: req_ready_o=1. Accept when req_valid_i=1: latch funct3, op1, op2, rd, reg_write; go to ISSUE.
- ISSUE: exactly one cycle; mul_start_o=1; counter cleared; go to WAIT.
- WAIT: counter increments every cycle.
  - mul_done_i=1: capture mul_result_i; go to WB if reg_write=1 and rd!=0, else go to IDLE and issue no write.
- WB: one cycle.
  - wb_valid_o=1, wb_rd_o=latched rd, wb_data_o=captured result.
  - alu_wb_ready_o=0 (controller has priority); ALU holds its request.
  - Then go to IDLE.
- Outside WB, alu_wb_ready_o=1 and the ALU request is passed through: wb_valid_o=alu_wb_valid_i, with rd/data muxed from the ALU path.
- mul_done_i is ignored in IDLE, ISSUE and WB.
- Latency: accept at cycle 0 -> start at cycle 1 -> done at cycle 1+MUL_LATENCY -> write at cycle 2+MUL_LATENCY. Back-to-back: next accept no earlier than the cycle after WB.
- hazard_o=1 when all hold: state in {ISSUE, WAIT, WB}; reg_write=1; rd!=0; dec_rs1_i==rd or dec_rs2_i==rd. Otherwise 0. hazard_o is combinational.
- flush_i:
  - In IDLE: no effect. The accept in the same cycle is blocked.
  - In ISSUE: start still pulses; go to DRAIN.
  - In WAIT: go to DRAIN. If mul_done_i=1 in the same cycle, discard the result and go to IDLE.
  - In WB: write still completes (op is already retired).
- DRAIN: the unit cannot abort. Wait for mul_done_i, discard the result, no write, hazard_o=0, then go to IDLE.
- Reset mid-operation: immediate return to IDLE; a later stray mul_done_i is ignored.
- Latched operands/funct3 are updated only on accept.

Optional Feature:
MULDIV_WATCHDOG_EN
- Defined: in WAIT or DRAIN, when the counter reaches TIMEOUT with no mul_done_i, error_o pulses for one cycle and the state returns to IDLE with no write.
- Undefined: counter saturates, error_o is tied to 0, and the controller waits indefinitely.

Decomposition:
- PARAMS_pkg gains the state enum muldiv_ctrl_state_t (IDLE, ISSUE, WAIT, WB, DRAIN) and MULDIV_CNT_W = $clog2(TIMEOUT+1).
- Existing package constants reused: WD_SIZE, INSTR_REG_SIZE, FUNCT3_SIZE, F3_*.
- One sub-module: muldiv_wb_arb, the 2:1 write-port priority mux (controller over ALU).

Test Plan:
- Basic MUL: accept funct3=MUL, op1=7, op2=6, rd=5. Unit done 5 cycles after start with result 42 -> start at cycle 1; wb_valid_o=1, wb_rd_o=5, wb_data_o=42 at cycle 7; hazard_o=1 for dec_rs1_i=5 during cycles 1-7.
- WB conflict: alu_wb_valid_i held 1 (rd=3, data=0xAA) during the MUL WB cycle -> alu_wb_ready_o=0 that cycle; ALU write (rd=3, 0xAA) appears the next cycle.
- rd=x0: accept op with rd=0 -> no wb_valid_o from the controller; hazard_o stays 0 for dec_rs1_i=0; return to IDLE after done.
- Flush in WAIT at cycle 3 -> DRAIN; done at cycle 6 is discarded; no write; req_ready_o=1 at cycle 7.
- Back-to-back: req_valid_i held 1 with two ops -> second accept only in the cycle after WB; exactly one mul_start_o per op.
- Watchdog (macro defined, TIMEOUT=16): no mul_done_i -> error_o pulses after 16 WAIT cycles, then IDLE. Macro undefined -> busy_o stays 1 and error_o stays 0.

Source files
------------

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared constants, state type and sizing helper for the MUL/DIV issue controller.
package muldiv_issue_ctrl_pkg;

    localparam int WD_SIZE        = 32;
    localparam int INSTR_REG_SIZE = 5;
    localparam int FUNCT3_SIZE    = 3;

    localparam logic [FUNCT3_SIZE-1:0] F3_MUL    = 3'b000;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULH   = 3'b001;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULHSU = 3'b010;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULHU  = 3'b011;
    localparam logic [FUNCT3_SIZE-1:0] F3_DIV    = 3'b100;
    localparam logic [FUNCT3_SIZE-1:0] F3_DIVU   = 3'b101;
    localparam logic [FUNCT3_SIZE-1:0] F3_REM    = 3'b110;
    localparam logic [FUNCT3_SIZE-1:0] F3_REMU   = 3'b111;

    localparam int MULDIV_LATENCY = 5;
    localparam int MULDIV_TIMEOUT = 16;

    // Counter must hold both the nominal latency and the watchdog limit.
    function automatic int muldiv_cnt_w(input int timeout, input int latency);
        return $clog2(((timeout > latency) ? timeout : latency) + 1);
    endfunction

    localparam int MULDIV_CNT_W = muldiv_cnt_w(MULDIV_TIMEOUT, MULDIV_LATENCY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WB    = 3'd3,
        DRAIN = 3'd4
    } muldiv_ctrl_state_t;

endpackage

// File: rtl/muldiv_wb_arb.sv
// Register-file write-port mux: the MUL/DIV controller always wins over the ALU.
module muldiv_wb_arb
    import muldiv_issue_ctrl_pkg::*;
(
    input  logic                      ctrl_valid_i,
    input  logic [INSTR_REG_SIZE-1:0] ctrl_rd_i,
    input  logic [WD_SIZE-1:0]        ctrl_data_i,
    input  logic                      alu_valid_i,
    input  logic [INSTR_REG_SIZE-1:0] alu_rd_i,
    input  logic [WD_SIZE-1:0]        alu_data_i,
    output logic                      alu_ready_o,
    output logic                      wb_valid_o,
    output logic [INSTR_REG_SIZE-1:0] wb_rd_o,
    output logic [WD_SIZE-1:0]        wb_data_o
);

    // Fixed priority; the ALU is simply stalled for the controller's write cycle.
    always_comb begin
        alu_ready_o = 1'b1;
        wb_valid_o  = alu_valid_i;
        wb_rd_o     = alu_rd_i;
        wb_data_o   = alu_data_i;
        if (ctrl_valid_i) begin
            alu_ready_o = 1'b0;
            wb_valid_o  = 1'b1;
            wb_rd_o     = ctrl_rd_i;
            wb_data_o   = ctrl_data_i;
        end
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue/sequence controller for the multi-cycle MUL/DIV unit: accepts one op,
// pulses start, tracks rd for RAW hazards, writes the result back, handles flush.
// Optional build macro MULDIV_WATCHDOG_EN: timeout in WAIT/DRAIN raises error_o.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = MULDIV_LATENCY,
    parameter int TIMEOUT     = MULDIV_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [FUNCT3_SIZE-1:0]    req_funct3_i,
    input  logic [WD_SIZE-1:0]        req_op1_i,
    input  logic [WD_SIZE-1:0]        req_op2_i,
    input  logic [INSTR_REG_SIZE-1:0] req_rd_i,
    input  logic                      req_reg_write_i,
    output logic                      mul_start_o,
    output logic [FUNCT3_SIZE-1:0]    mul_funct3_o,
    output logic [WD_SIZE-1:0]        mul_op1_o,
    output logic [WD_SIZE-1:0]        mul_op2_o,
    input  logic                      mul_done_i,
    input  logic [WD_SIZE-1:0]        mul_result_i,
    input  logic                      flush_i,
    input  logic [INSTR_REG_SIZE-1:0] dec_rs1_i,
    input  logic [INSTR_REG_SIZE-1:0] dec_rs2_i,
    output logic                      hazard_o,
    input  logic                      alu_wb_valid_i,
    input  logic [INSTR_REG_SIZE-1:0] alu_wb_rd_i,
    input  logic [WD_SIZE-1:0]        alu_wb_data_i,
    output logic                      alu_wb_ready_o,
    output logic                      wb_valid_o,
    output logic [INSTR_REG_SIZE-1:0] wb_rd_o,
    output logic [WD_SIZE-1:0]        wb_data_o,
    output logic                      busy_o,
    output logic                      error_o
);

    localparam int CNT_W = muldiv_cnt_w(TIMEOUT, MUL_LATENCY);

    muldiv_ctrl_state_t        state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [WD_SIZE-1:0]        result_q, result_d;
    logic                      err_q, err_d;
    logic                      accept;
    logic [FUNCT3_SIZE-1:0]    funct3_q;
    logic [WD_SIZE-1:0]        op1_q, op2_q;
    logic [INSTR_REG_SIZE-1:0] rd_q;
    logic                      rw_q;
    logic                      writes_rd;
    logic                      in_flight;

`ifdef MULDIV_WATCHDOG_EN
    logic timeout_hit;
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
`else
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`endif

    assign writes_rd = rw_q && (rd_q != '0);
    assign in_flight = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WB);

    // Next-state logic; done is only honoured in WAIT and DRAIN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = flush_i ? DRAIN : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (mul_done_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        result_d = mul_result_i;
                        state_d  = writes_rd ? WB : IDLE;
                    end
                end
`ifdef MULDIV_WATCHDOG_EN
                else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
                else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            DRAIN: begin
                cnt_d = cnt_inc;
                if (mul_done_i) begin
                    state_d = IDLE;
                end
`ifdef MULDIV_WATCHDOG_EN
                else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, cycle counter, captured result and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Operand latches change only on accept so the unit sees stable inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
        end else if (accept) begin
            funct3_q <= req_funct3_i;
            op1_q    <= req_op1_i;
            op2_q    <= req_op2_i;
            rd_q     <= req_rd_i;
            rw_q     <= req_reg_write_i;
        end
    end

    assign req_ready_o  = (state_q == IDLE) && !flush_i;
    assign mul_start_o  = (state_q == ISSUE);
    assign mul_funct3_o = funct3_q;
    assign mul_op1_o    = op1_q;
    assign mul_op2_o    = op2_q;
    assign busy_o       = (state_q != IDLE);
    assign hazard_o     = in_flight && writes_rd &&
                          ((dec_rs1_i == rd_q) || (dec_rs2_i == rd_q));
`ifdef MULDIV_WATCHDOG_EN
    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    muldiv_wb_arb u_wb_arb (
        .ctrl_valid_i (state_q == WB),
        .ctrl_rd_i    (rd_q),
        .ctrl_data_i  (result_q),
        .alu_valid_i  (alu_wb_valid_i),
        .alu_rd_i     (alu_wb_rd_i),
        .alu_data_i   (alu_wb_data_i),
        .alu_ready_o  (alu_wb_ready_o),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o)
    );

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: directed scenarios plus randomized ops, checked
// against an op-timeline model (accept at k=0, start k=1, done k=1+lat, write k=2+lat).
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    localparam int ML = MULDIV_LATENCY;
    localparam int TO = MULDIV_TIMEOUT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0, req_reg_write_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_op1_i = '0, req_op2_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        req_ready_o, mul_start_o;
    logic [2:0]  mul_funct3_o;
    logic [31:0] mul_op1_o, mul_op2_o;
    logic        mul_done_i = 1'b0;
    logic [31:0] mul_result_i = '0;
    logic        flush_i = 1'b0;
    logic [4:0]  dec_rs1_i = '0, dec_rs2_i = '0;
    logic        hazard_o;
    logic        alu_wb_valid_i = 1'b0;
    logic [4:0]  alu_wb_rd_i = '0;
    logic [31:0] alu_wb_data_i = '0;
    logic        alu_wb_ready_o, wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o, error_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_issue_ctrl #(.MUL_LATENCY(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
        .req_rd_i(req_rd_i), .req_reg_write_i(req_reg_write_i),
        .mul_start_o(mul_start_o), .mul_funct3_o(mul_funct3_o),
        .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
        .mul_done_i(mul_done_i), .mul_result_i(mul_result_i),
        .flush_i(flush_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
        .hazard_o(hazard_o),
        .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_rd_i(alu_wb_rd_i),
        .alu_wb_data_i(alu_wb_data_i), .alu_wb_ready_o(alu_wb_ready_o),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural stand-in for the arithmetic unit's answer.
    function automatic logic [31:0] unit_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (f3)
            F3_MUL:   return p[31:0];
            F3_MULHU: return p[63:32];
            F3_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REMU:  return (b == 0) ? a : a % b;
            default:  return a ^ b;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_alu_ready"}, 32'(alu_wb_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_start"}, 32'(mul_start_o), 32'd0);
        chk({tag, "_hazard"}, 32'(hazard_o), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
        chk({tag, "_wb_data"}, wb_data_o, 32'd0);
        chk({tag, "_f3"}, 32'(mul_funct3_o), 32'd0);
        chk({tag, "_op1"}, mul_op1_o, 32'd0);
        chk({tag, "_op2"}, mul_op2_o, 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
    endtask

    task automatic drive_quiet();
        req_valid_i = 0; req_funct3_i = '0; req_op1_i = '0; req_op2_i = '0;
        req_rd_i = '0; req_reg_write_i = 0; mul_done_i = 0; mul_result_i = '0;
        flush_i = 0; dec_rs1_i = '0; dec_rs2_i = '0;
        alu_wb_valid_i = 0; alu_wb_rd_i = '0; alu_wb_data_i = '0;
    endtask

    // One idle cycle; a request is only presented together with flush (must be blocked).
    task automatic idle_cycle(input bit fl, input bit stray, input bit av,
                              input logic [4:0] ar, input logic [31:0] ad);
        req_valid_i = fl; flush_i = fl; mul_done_i = stray;
        mul_result_i = $urandom;
        req_funct3_i = 3'($urandom_range(0, 7)); req_op1_i = $urandom; req_op2_i = $urandom;
        req_rd_i = 5'($urandom_range(0, 31)); req_reg_write_i = 1;
        dec_rs1_i = 5'($urandom_range(0, 31)); dec_rs2_i = 5'($urandom_range(0, 31));
        alu_wb_valid_i = av; alu_wb_rd_i = ar; alu_wb_data_i = ad;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready_o), 32'(!fl));
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_start", 32'(mul_start_o), 32'd0);
        chk("idle_hazard", 32'(hazard_o), 32'd0);
        chk("idle_alu_ready", 32'(alu_wb_ready_o), 32'd1);
        chk("idle_wb_valid", 32'(wb_valid_o), 32'(av));
        chk("idle_wb_rd", 32'(wb_rd_o), 32'(ar));
        chk("idle_wb_data", wb_data_o, ad);
        chk("idle_error", 32'(error_o), 32'd0);
        next_cycle();
    endtask

    // One complete op. fl: cycle at which flush is raised (-1 = never).
    // req_valid_i stays high the whole time so a premature re-accept would show.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit rw, input int lat, input int fl,
                          input int rs1_fix, input bit alu_hold, input bit stray);
        bit flushed = (fl >= 1) && (fl <= 1 + lat);
        bit writes = !flushed && rw && (rd != 0);
        int wb_k = 2 + lat;
        int last = writes ? 2 + lat : 1 + lat;
        int hz_end = flushed ? fl : last;
        logic [31:0] res = unit_ref(f3, a, b);
        bit exp_hz, is_wb;
        for (int k = 0; k <= last; k++) begin
            req_valid_i = 1;
            if (k == 0) begin
                req_funct3_i = f3; req_op1_i = a; req_op2_i = b; req_rd_i = rd; req_reg_write_i = rw;
            end else begin
                req_funct3_i = 3'($urandom_range(0, 7)); req_op1_i = $urandom; req_op2_i = $urandom;
                req_rd_i = 5'($urandom_range(0, 31)); req_reg_write_i = 1'($urandom_range(0, 1));
            end
            flush_i = (k == fl);
            mul_done_i = (k == 1 + lat) || (stray && (k == 1 || (writes && k == wb_k)));
            mul_result_i = (k == 1 + lat) ? res : $urandom;
            dec_rs1_i = (rs1_fix >= 0) ? 5'(rs1_fix) : ($urandom_range(0, 1) ? rd : 5'($urandom_range(0, 31)));
            dec_rs2_i = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            if (alu_hold) begin
                alu_wb_valid_i = 1; alu_wb_rd_i = 5'd3; alu_wb_data_i = 32'hAA;
            end else begin
                alu_wb_valid_i = 1'($urandom_range(0, 1));
                alu_wb_rd_i = 5'($urandom_range(0, 31)); alu_wb_data_i = $urandom;
            end
            @(negedge clk);
            exp_hz = (k >= 1) && (k <= hz_end) && rw && (rd != 0) &&
                     ((dec_rs1_i == rd) || (dec_rs2_i == rd));
            is_wb = writes && (k == wb_k);
            chk("op_ready", 32'(req_ready_o), 32'(k == 0));
            chk("op_busy", 32'(busy_o), 32'(k != 0));
            chk("op_start", 32'(mul_start_o), 32'(k == 1));
            chk("op_hazard", 32'(hazard_o), 32'(exp_hz));
            chk("op_error", 32'(error_o), 32'd0);
            chk("op_alu_ready", 32'(alu_wb_ready_o), 32'(!is_wb));
            chk("op_wb_valid", 32'(wb_valid_o), is_wb ? 32'd1 : 32'(alu_wb_valid_i));
            chk("op_wb_rd", 32'(wb_rd_o), is_wb ? 32'(rd) : 32'(alu_wb_rd_i));
            chk("op_wb_data", wb_data_o, is_wb ? res : alu_wb_data_i);
            if (k >= 1) begin
                chk("op_latched_f3", 32'(mul_funct3_o), 32'(f3));
                chk("op_latched_op1", mul_op1_o, a);
                chk("op_latched_op2", mul_op2_o, b);
            end
            next_cycle();
        end
        req_valid_i = 0;
        flush_i = 0;
        mul_done_i = 0;
    endtask

    initial begin
        int lat, fl, ng;
        bit wd_en;
`ifdef MULDIV_WATCHDOG_EN
        wd_en = 1;
`else
        wd_en = 0;
`endif
        drive_quiet();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 reset = 0;

        // Basic MUL 7*6 -> rd5, write at cycle 7, hazard on rs1=5 cycles 1..7.
        run_op(F3_MUL, 32'd7, 32'd6, 5'd5, 1, ML, -1, 5, 0, 0);
        idle_cycle(0, 0, 0, 5'd0, 32'd0);

        // ALU held during the MUL write cycle, then granted the following cycle.
        run_op(F3_MUL, 32'd3, 32'd9, 5'd12, 1, ML, -1, -1, 1, 0);
        idle_cycle(0, 0, 1, 5'd3, 32'hAA);

        // rd = x0: no controller write and no hazard.
        run_op(F3_MUL, 32'd11, 32'd2, 5'd0, 1, ML, -1, 0, 0, 1);
        idle_cycle(0, 0, 0, 5'd0, 32'd0);

        // Flush in WAIT at cycle 3; done at cycle 6 discarded; idle at cycle 7.
        run_op(F3_DIVU, 32'd100, 32'd7, 5'd9, 1, ML, 3, 9, 0, 0);
        // Flush coinciding with done, flush in ISSUE, flush during WB.
        run_op(F3_REMU, 32'd100, 32'd7, 5'd9, 1, ML, 1 + ML, 9, 0, 0);
        run_op(F3_MULHU, 32'hFFFF_0000, 32'h1234, 5'd17, 1, 2, 1, 17, 0, 1);
        run_op(F3_MUL, 32'd5, 32'd5, 5'd20, 1, 3, 5, 20, 0, 0);

        // Back-to-back with req_valid_i held high.
        run_op(F3_MUL, 32'd13, 32'd3, 5'd1, 1, ML, -1, -1, 0, 0);
        run_op(F3_DIVU, 32'd81, 32'd9, 5'd2, 1, 1, -1, -1, 0, 0);

        // Flush in IDLE blocks an accept.
        idle_cycle(1, 1, 0, 5'd0, 32'd0);
        idle_cycle(0, 0, 0, 5'd0, 32'd0);

        // Unit never answers.
        req_valid_i = 1; req_funct3_i = F3_DIV; req_op1_i = 32'd50; req_op2_i = 32'd5;
        req_rd_i = 5'd9; req_reg_write_i = 1;
        for (int k = 0; k <= 2 + TO; k++) begin
            @(negedge clk);
            if (wd_en) begin
                chk("wd_busy", 32'(busy_o), 32'((k >= 1) && (k <= 1 + TO)));
                chk("wd_error", 32'(error_o), 32'(k == 2 + TO));
            end else begin
                chk("wd_busy", 32'(busy_o), 32'(k >= 1));
                chk("wd_error", 32'(error_o), 32'd0);
            end
            next_cycle();
            req_valid_i = 0;
        end

        // Async reset mid-operation, then a stray done must be ignored.
        drive_quiet();
        #2 reset = 1;
        #1;
        check_reset_vals("reset_mid");
        next_cycle();
        reset = 0;
        run_op(F3_MUL, 32'd4, 32'd4, 5'd6, 1, 1, -1, -1, 0, 0);
        req_valid_i = 1; req_funct3_i = F3_MUL; req_op1_i = 32'd8; req_op2_i = 32'd8;
        req_rd_i = 5'd7; req_reg_write_i = 1;
        repeat (3) next_cycle();
        drive_quiet();
        #2 reset = 1;
        #1;
        check_reset_vals("reset_mid2");
        next_cycle();
        reset = 0;
        idle_cycle(0, 1, 0, 5'd0, 32'd0);
        idle_cycle(0, 1, 0, 5'd0, 32'd0);

        // Randomized ops with random gaps.
        for (int n = 0; n < 40; n++) begin
            lat = $urandom_range(1, 8);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + lat) : -1;
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   ($urandom_range(0, 4) != 0), lat, fl, -1, 0, 1'($urandom_range(0, 1)));
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++)
                idle_cycle(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
